// File: rtl/dac_sample_pacer.sv
// dac_sample_pacer: buffers core samples in a small FIFO and releases one per
// programmable period to the DAC input register. It also drives a hysteretic
// level indicator and a sticky underrun flag.
module dac_sample_pacer #(
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_i,
    input  logic                             enable,
    input  logic [DIV_W-1:0]                 period,
    input  logic [DATA_W-1:0]                thr_hi,
    input  logic [DATA_W-1:0]                thr_lo,
    input  logic                             s_valid,
    input  logic [DATA_W-1:0]                s_data,
    output logic                             s_ready,
    output logic [DATA_W-1:0]                dac_out,
    output logic                             dac_strobe,
    output logic                             level_out,
    output logic                             underrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]    count_q;
    logic [DATA_W-1:0]   dac_q;
    logic                strobe_q;
    logic                level_q;
    logic                underrun_q;

    logic                full, empty, push, tick, act, pop, flush;
    logic [DIV_W-1:0]    reload;

    assign full    = (count_q == FULL_LVL);
    assign empty   = (count_q == '0);
    assign s_ready = !full && (state_q != StIdle);
    assign push    = s_valid && s_ready;
    assign tick    = (state_q == StRun) && (cnt_q == '0);
    // A tick only acts while enable is held; dropping enable discards it.
    assign act     = tick && enable;
    assign pop     = act && !empty;
    assign flush   = (state_q == StIdle) || !enable;
    // A zero period behaves as one cycle per update.
    assign reload  = (period == '0) ? '0 : period - DIV_W'(1);

    // Next-state logic for the run FSM and the period counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle:  if (enable) state_d = StPrime;
            StPrime: begin
                if (!enable)   state_d = StIdle;
                else if (full) state_d = StRun;
            end
            StRun:   if (!enable) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Counter only runs while staying in RUN; entering RUN starts at 0 so the
        // first RUN cycle ticks.
        if ((state_q == StRun) && (state_d == StRun)) begin
            if (tick) cnt_d = reload;
            else      cnt_d = cnt_q - DIV_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // FSM state and period counter registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sample FIFO: storage, pointers and occupancy; flushed whenever idle or disabled.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= s_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + LVL_W'(1);
                2'b01:   count_q <= count_q - LVL_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // DAC code register and one-cycle strobe, loaded from the FIFO head on a pop.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            dac_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= pop;
            if (pop) dac_q <= mem_q[rd_ptr_q];
        end
    end

    // Sticky underrun: set by a live tick on an empty FIFO, cleared on IDLE->PRIME.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            underrun_q <= 1'b0;
        end else if (act && empty) begin
            underrun_q <= 1'b1;
        end else if ((state_q == StIdle) && enable) begin
            underrun_q <= 1'b0;
        end
    end

    // Hysteretic level indicator, re-evaluated on the new code while the strobe is high.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            level_q <= 1'b0;
        end else if (strobe_q) begin
            if (dac_q >= thr_hi)      level_q <= 1'b1;
            else if (dac_q <= thr_lo) level_q <= 1'b0;
        end
    end

    assign dac_out    = dac_q;
    assign dac_strobe = strobe_q;
    assign level_out  = level_q;
    assign underrun   = underrun_q;
    assign fifo_level = count_q;

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Directed testbench for dac_sample_pacer: priming, pacing, underrun, hysteresis,
// flush on disable, back-to-back pacing and asynchronous reset.
module tb_dac_sample_pacer;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        enable   = 1'b0;
    logic [15:0] period   = 16'd3;
    logic [9:0]  thr_hi   = 10'd900;
    logic [9:0]  thr_lo   = 10'd100;
    logic        s_valid  = 1'b0;
    logic [9:0]  s_data   = '0;
    logic        s_ready;
    logic [9:0]  dac_out;
    logic        dac_strobe;
    logic        level_out;
    logic        underrun;
    logic [2:0]  fifo_level;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] src_q[$];
    int         idx = 0;

    dac_sample_pacer #(
        .DATA_W     (10),
        .FIFO_DEPTH (4),
        .DIV_W      (16)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .enable     (enable),
        .period     (period),
        .thr_hi     (thr_hi),
        .thr_lo     (thr_lo),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .dac_out    (dac_out),
        .dac_strobe (dac_strobe),
        .level_out  (level_out),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        if (idx < src_q.size()) begin
            s_valid = 1'b1;
            s_data  = src_q[idx];
        end else begin
            s_valid = 1'b0;
            s_data  = '0;
        end
    endtask

    // One clock: push the current source sample if accepted, then present the next.
    task automatic feed_step();
        logic fire;
        fire = s_valid && s_ready;
        @(posedge wb_clk_i);
        #1;
        if (fire) idx++;
        drive_src();
    endtask

    task automatic wait_strobe(input int bound, output int cycles);
        cycles = 0;
        do begin
            feed_step();
            cycles++;
        end while (!dac_strobe && cycles < bound);
    endtask

    task automatic load4(input logic [9:0] a, input logic [9:0] b,
                         input logic [9:0] c, input logic [9:0] d);
        src_q.delete();
        src_q.push_back(a);
        src_q.push_back(b);
        src_q.push_back(c);
        src_q.push_back(d);
        idx = 0;
    endtask

    task automatic start_run(input logic [15:0] p);
        period = p;
        enable = 1'b1;
        drive_src();
        feed_step();
    endtask

    task automatic go_idle();
        enable  = 1'b0;
        s_valid = 1'b0;
        @(posedge wb_clk_i);
        #1;
    endtask

    initial begin
        int lat;
        int strobes;
        int rises;
        int falls;
        int extra;
        logic lvl_prev;

        // Reset state
        repeat (2) @(posedge wb_clk_i);
        #1;
        check_eq("rst_dac", 32'(dac_out), 0);
        check_eq("rst_strobe", 32'(dac_strobe), 0);
        check_eq("rst_level", 32'(level_out), 0);
        check_eq("rst_underrun", 32'(underrun), 0);
        check_eq("rst_ready", 32'(s_ready), 0);
        check_eq("rst_fifo", 32'(fifo_level), 0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1;
        check_eq("idle_ready", 32'(s_ready), 0);

        // T2: period 3, four samples; 4 pushes + transition + tick -> strobe 6 cycles
        // after entering PRIME, then every 3 cycles.
        load4(10'd0, 10'd341, 10'd682, 10'd1023);
        start_run(16'd3);
        check_eq("t2_prime_ready", 32'(s_ready), 1);
        check_eq("t2_prime_fifo", 32'(fifo_level), 0);
        wait_strobe(20, lat);
        check_eq("t2_lat0", 32'(lat), 6);
        check_eq("t2_dac0", 32'(dac_out), 0);
        check_eq("t2_fifo_after_pop", 32'(fifo_level), 3);
        wait_strobe(20, lat);
        check_eq("t2_gap1", 32'(lat), 3);
        check_eq("t2_dac1", 32'(dac_out), 341);
        wait_strobe(20, lat);
        check_eq("t2_gap2", 32'(lat), 3);
        check_eq("t2_dac2", 32'(dac_out), 682);
        wait_strobe(20, lat);
        check_eq("t2_gap3", 32'(lat), 3);
        check_eq("t2_dac3", 32'(dac_out), 1023);
        feed_step();
        check_eq("t2_level_set", 32'(level_out), 1);
        check_eq("t2_strobe_pulse", 32'(dac_strobe), 0);
        go_idle();

        // T3: period 2; the 5th tick finds the FIFO empty two edges after the 4th strobe.
        load4(10'd0, 10'd341, 10'd682, 10'd1023);
        start_run(16'd2);
        wait_strobe(20, lat);
        check_eq("t3_lat0", 32'(lat), 6);
        for (int k = 1; k < 4; k++) begin
            wait_strobe(20, lat);
            check_eq("t3_gap", 32'(lat), 2);
        end
        check_eq("t3_dac_last", 32'(dac_out), 1023);
        feed_step();
        check_eq("t3_underrun_early", 32'(underrun), 0);
        feed_step();
        check_eq("t3_underrun_set", 32'(underrun), 1);
        check_eq("t3_no_strobe", 32'(dac_strobe), 0);
        check_eq("t3_dac_hold", 32'(dac_out), 1023);
        feed_step();
        check_eq("t3_no_strobe2", 32'(dac_strobe), 0);
        go_idle();
        check_eq("t3_idle_underrun_hold", 32'(underrun), 1);
        check_eq("t3_idle_dac_hold", 32'(dac_out), 1023);
        check_eq("t3_idle_level_hold", 32'(level_out), 1);

        // T5: disable in RUN with two entries left.
        load4(10'd0, 10'd341, 10'd682, 10'd1023);
        start_run(16'd3);
        check_eq("t5_underrun_clr", 32'(underrun), 0);
        wait_strobe(20, lat);
        wait_strobe(20, lat);
        check_eq("t5_dac1", 32'(dac_out), 341);
        check_eq("t5_fifo2", 32'(fifo_level), 2);
        go_idle();
        check_eq("t5_fifo_flushed", 32'(fifo_level), 0);
        check_eq("t5_ready_low", 32'(s_ready), 0);
        check_eq("t5_dac_held", 32'(dac_out), 341);
        check_eq("t5_level_held", 32'(level_out), 0);
        feed_step();
        check_eq("t5_dac_still", 32'(dac_out), 341);
        check_eq("t5_no_strobe", 32'(dac_strobe), 0);
        // Re-enable: old contents gone, PRIME refills with new samples.
        load4(10'd5, 10'd6, 10'd7, 10'd8);
        start_run(16'd3);
        check_eq("t5_reprime_ready", 32'(s_ready), 1);
        check_eq("t5_reprime_fifo", 32'(fifo_level), 0);
        wait_strobe(20, lat);
        check_eq("t5_relat", 32'(lat), 6);
        check_eq("t5_refill_head", 32'(dac_out), 5);
        go_idle();

        // T4: three ramps 0..960,1023,960..64 with thresholds 900/100, period 2.
        src_q.delete();
        idx = 0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 16; k++) src_q.push_back(10'(64 * k));
            src_q.push_back(10'd1023);
            for (int k = 15; k >= 1; k--) src_q.push_back(10'(64 * k));
        end
        start_run(16'd2);
        strobes  = 0;
        rises    = 0;
        falls    = 0;
        extra    = 0;
        lvl_prev = level_out;
        for (int c = 0; c < 500; c++) begin
            feed_step();
            if (dac_strobe) begin
                strobes++;
                if (strobes == 96) check_eq("t4_no_underrun", 32'(underrun), 0);
            end
            if (level_out && !lvl_prev) begin
                rises++;
                check_eq("t4_rise_code", 32'(dac_out), 960);
            end
            if (!level_out && lvl_prev) begin
                falls++;
                check_eq("t4_fall_code", 32'(dac_out), 64);
            end
            lvl_prev = level_out;
            if (strobes >= 96) extra++;
            if (extra >= 4) break;
        end
        check_eq("t4_strobes", 32'(strobes), 96);
        check_eq("t4_rises", 32'(rises), 3);
        check_eq("t4_falls", 32'(falls), 3);
        go_idle();

        // T6: period 0 with a continuous source -> strobe every cycle, in order.
        src_q.delete();
        idx = 0;
        for (int k = 0; k < 64; k++) src_q.push_back(10'(900 + k));
        start_run(16'd0);
        wait_strobe(20, lat);
        check_eq("t6_lat0", 32'(lat), 6);
        check_eq("t6_dac0", 32'(dac_out), 900);
        for (int k = 1; k <= 20; k++) begin
            feed_step();
            check_eq("t6_strobe", 32'(dac_strobe), 1);
            check_eq("t6_dac", 32'(dac_out), 900 + k);
            check_eq("t6_underrun", 32'(underrun), 0);
            check_eq("t6_fifo_band", 32'((fifo_level == 3'd3) || (fifo_level == 3'd4)), 1);
        end
        check_eq("t6_level_set", 32'(level_out), 1);

        // T1: asynchronous reset mid-RUN, observed before the next clock edge.
        #2;
        wb_rst_i = 1'b1;
        #1;
        check_eq("t1_dac", 32'(dac_out), 0);
        check_eq("t1_strobe", 32'(dac_strobe), 0);
        check_eq("t1_level", 32'(level_out), 0);
        check_eq("t1_underrun", 32'(underrun), 0);
        check_eq("t1_ready", 32'(s_ready), 0);
        check_eq("t1_fifo", 32'(fifo_level), 0);
        enable  = 1'b0;
        s_valid = 1'b0;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1;
        check_eq("t1_post_ready", 32'(s_ready), 0);
        check_eq("t1_post_dac", 32'(dac_out), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
